// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator. It walks a (hpos, vpos) position
// through an H_TOTAL x V_TOTAL raster, one position per enabled clock. For
// that position it produces sync, blanking and frame-event signals.
//
// Every output is registered. Sync, blanking and ticks are decoded from the
// *next* position and loaded on the same edge as the position itself. As a
// result, all outputs always describe the same pixel.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_pix_en       pixel-advance enable; position steps only when high
//   o_hsync        horizontal sync, HSYNC_POL level inside the sync region
//   o_vsync        vertical sync, VSYNC_POL level inside the sync region
//   o_display_on   high while the position is inside the active area
//   o_hpos         current pixel column
//   o_vpos         current line
//   o_line_tick    one-cycle pulse on entry to hpos = 0
//   o_frame_tick   one-cycle pulse on entry to (0, 0)
//   o_vblank_tick  one-cycle pulse on entry to (0, V_DISPLAY)
//   o_frame_count  frames started since reset, wraps
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned FRAME_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_en,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_display_on,
    output logic [CNT_W-1:0]   o_hpos,
    output logic [CNT_W-1:0]   o_vpos,
    output logic               o_line_tick,
    output logic               o_frame_tick,
    output logic               o_vblank_tick,
    output logic [FRAME_W-1:0] o_frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    // Reject modes whose raster cannot be counted or that lack a porch/sync.
    if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must all be non-zero");
    end
    if (64'(H_TOTAL - 1) > CNT_MAX || 64'(V_TOTAL - 1) > CNT_MAX) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);
    localparam logic [CNT_W-1:0]   H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]   V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]   H_ACT     = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0]   V_ACT     = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0]   HS_BEG    = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0]   HS_END    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0]   VS_BEG    = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0]   VS_END    = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [CNT_W-1:0]   r_hpos;
    logic [CNT_W-1:0]   r_vpos;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_display_on;
    logic               r_line_tick;
    logic               r_frame_tick;
    logic               r_vblank_tick;
    logic [FRAME_W-1:0] r_frame_count;

    logic [CNT_W-1:0]   w_hpos_nxt;
    logic [CNT_W-1:0]   w_vpos_nxt;
    logic               w_de_nxt;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_line_nxt;
    logic               w_frame_nxt;
    logic               w_vblank_nxt;

    // Position that the next enabled edge will enter.
    always_comb begin
        w_hpos_nxt = r_hpos + CNT_ONE;
        w_vpos_nxt = r_vpos;
        if (r_hpos == H_LAST) begin
            w_hpos_nxt = '0;
            w_vpos_nxt = (r_vpos == V_LAST) ? '0 : r_vpos + CNT_ONE;
        end
    end

    // Decode from the next position so the registered outputs line up with it.
    always_comb begin
        w_de_nxt     = (w_hpos_nxt < H_ACT) && (w_vpos_nxt < V_ACT);
        w_hs_act     = (w_hpos_nxt >= HS_BEG) && (w_hpos_nxt < HS_END);
        w_vs_act     = (w_vpos_nxt >= VS_BEG) && (w_vpos_nxt < VS_END);
        w_line_nxt   = (w_hpos_nxt == '0);
        w_frame_nxt  = w_line_nxt && (w_vpos_nxt == '0);
        w_vblank_nxt = w_line_nxt && (w_vpos_nxt == V_ACT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // Parked on the last position so the first enabled edge enters (0,0).
            r_hpos        <= H_LAST;
            r_vpos        <= V_LAST;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_display_on  <= 1'b0;
            r_line_tick   <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_vblank_tick <= 1'b0;
            r_frame_count <= '0;
        end else begin
            // Ticks are only ever one clock wide: cleared on every non-stepping edge.
            r_line_tick   <= i_pix_en && w_line_nxt;
            r_frame_tick  <= i_pix_en && w_frame_nxt;
            r_vblank_tick <= i_pix_en && w_vblank_nxt;
            if (i_pix_en) begin
                r_hpos       <= w_hpos_nxt;
                r_vpos       <= w_vpos_nxt;
                r_display_on <= w_de_nxt;
                r_hsync      <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
                r_vsync      <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
                if (w_frame_nxt) begin
                    r_frame_count <= r_frame_count + FRAME_ONE;
                end
            end
        end
    end

    assign o_hpos        = r_hpos;
    assign o_vpos        = r_vpos;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_display_on  = r_display_on;
    assign o_line_tick   = r_line_tick;
    assign o_frame_tick  = r_frame_tick;
    assign o_vblank_tick = r_vblank_tick;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen. It runs two instances from one clock:
//   dut_a  default 640x480 mode
//   dut_b  small mode (H 8/2/2/2, V 4/1/1/1, HSYNC_POL=1, CNT_W=4, FRAME_W=2)
// A behavioural raster model pushes the expected outputs of each instance
// when a cycle is driven. The scenario tasks pop those expectations after
// the edge and compare them with the outputs.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] h;
        logic [9:0] v;
        logic       lt;
        logic       ft;
        logic       vt;
        logic [7:0] fc;
    } out_t;

    typedef struct {
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
        bit hp; bit vp; int fmod;
    } mode_t;

    localparam out_t RST_A   = '{hs:1'b1, vs:1'b1, de:1'b0, h:10'd799, v:10'd524,
                                 lt:1'b0, ft:1'b0, vt:1'b0, fc:8'd0};
    localparam out_t RST_B   = '{hs:1'b0, vs:1'b1, de:1'b0, h:10'd13, v:10'd6,
                                 lt:1'b0, ft:1'b0, vt:1'b0, fc:8'd0};
    localparam out_t FIRST_A = '{hs:1'b1, vs:1'b1, de:1'b1, h:10'd0, v:10'd0,
                                 lt:1'b1, ft:1'b1, vt:1'b0, fc:8'd1};
    localparam out_t FIRST_B = '{hs:1'b0, vs:1'b1, de:1'b1, h:10'd0, v:10'd0,
                                 lt:1'b1, ft:1'b1, vt:1'b0, fc:8'd1};

    logic       clk;
    logic       rst_n;
    logic       pix_en;

    logic       a_hs, a_vs, a_de, a_lt, a_ft, a_vt;
    logic [9:0] a_h, a_v;
    logic [7:0] a_fc;
    logic       b_hs, b_vs, b_de, b_lt, b_ft, b_vt;
    logic [3:0] b_h, b_v;
    logic [1:0] b_fc;

    int    n_vec = 0;
    int    n_err = 0;
    mode_t md[2];
    int    mh[2], mv[2], mfc[2];
    bit    mlt[2], mft[2], mvt[2];
    out_t  q_a[$];
    out_t  q_b[$];
    out_t  ea, eb, oa, ob;

    vga_timing_gen dut_a (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pix_en      (pix_en),
        .o_hsync       (a_hs),
        .o_vsync       (a_vs),
        .o_display_on  (a_de),
        .o_hpos        (a_h),
        .o_vpos        (a_v),
        .o_line_tick   (a_lt),
        .o_frame_tick  (a_ft),
        .o_vblank_tick (a_vt),
        .o_frame_count (a_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .CNT_W (4), .FRAME_W (2)
    ) dut_b (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pix_en      (pix_en),
        .o_hsync       (b_hs),
        .o_vsync       (b_vs),
        .o_display_on  (b_de),
        .o_hpos        (b_h),
        .o_vpos        (b_v),
        .o_line_tick   (b_lt),
        .o_frame_tick  (b_ft),
        .o_vblank_tick (b_vt),
        .o_frame_count (b_fc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic out_t obs_a();
        return '{hs:a_hs, vs:a_vs, de:a_de, h:a_h, v:a_v, lt:a_lt, ft:a_ft, vt:a_vt, fc:a_fc};
    endfunction

    function automatic out_t obs_b();
        return '{hs:b_hs, vs:b_vs, de:b_de, h:10'(b_h), v:10'(b_v), lt:b_lt, ft:b_ft,
                 vt:b_vt, fc:8'(b_fc)};
    endfunction

    // Expected outputs for the model position of instance k.
    function automatic out_t model_out(input int k);
        out_t o;
        int   hs0, vs0;
        hs0  = md[k].hd + md[k].hf;
        vs0  = md[k].vd + md[k].vf;
        o.h  = 10'(mh[k]);
        o.v  = 10'(mv[k]);
        o.de = (mh[k] < md[k].hd) && (mv[k] < md[k].vd);
        o.hs = (mh[k] >= hs0 && mh[k] < hs0 + md[k].hs) ? md[k].hp : !md[k].hp;
        o.vs = (mv[k] >= vs0 && mv[k] < vs0 + md[k].vs) ? md[k].vp : !md[k].vp;
        o.lt = mlt[k];
        o.ft = mft[k];
        o.vt = mvt[k];
        o.fc = 8'(mfc[k]);
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mh[k]  = md[k].hd + md[k].hf + md[k].hs + md[k].hb - 1;
            mv[k]  = md[k].vd + md[k].vf + md[k].vs + md[k].vb - 1;
            mfc[k] = 0;
            mlt[k] = 1'b0;
            mft[k] = 1'b0;
            mvt[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit en);
        for (int k = 0; k < 2; k++) begin
            mlt[k] = 1'b0;
            mft[k] = 1'b0;
            mvt[k] = 1'b0;
            if (en) begin
                mh[k] = mh[k] + 1;
                if (mh[k] == md[k].hd + md[k].hf + md[k].hs + md[k].hb) begin
                    mh[k] = 0;
                    mv[k] = mv[k] + 1;
                    if (mv[k] == md[k].vd + md[k].vf + md[k].vs + md[k].vb) mv[k] = 0;
                end
                mlt[k] = (mh[k] == 0);
                mft[k] = mlt[k] && (mv[k] == 0);
                mvt[k] = mlt[k] && (mv[k] == md[k].vd);
                if (mft[k]) mfc[k] = (mfc[k] + 1) % md[k].fmod;
            end
        end
    endtask

    // Drive one cycle, queue what both instances must show after it.
    task automatic drive(input bit en);
        pix_en = en;
        model_step(en);
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (obs_a() !== RST_A) begin
            n_err++;
            $display("FAIL reset_a got %h want %h", obs_a(), RST_A);
        end
        n_vec++;
        if (obs_b() !== RST_B) begin
            n_err++;
            $display("FAIL reset_b got %h want %h", obs_b(), RST_B);
        end
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0);
            ea = q_a.pop_front(); oa = obs_a();
            eb = q_b.pop_front(); ob = obs_b();
            n_vec += 2;
            if (oa !== ea) begin n_err++; $display("FAIL hold_a got %h want %h", oa, ea); end
            if (ob !== eb) begin n_err++; $display("FAIL hold_b got %h want %h", ob, eb); end
        end
    endtask

    task automatic test_first_frame();
        drive(1'b1);
        ea = q_a.pop_front(); oa = obs_a();
        eb = q_b.pop_front(); ob = obs_b();
        n_vec += 4;
        if (oa !== ea)      begin n_err++; $display("FAIL first_a got %h want %h", oa, ea); end
        if (ob !== eb)      begin n_err++; $display("FAIL first_b got %h want %h", ob, eb); end
        if (oa !== FIRST_A) begin n_err++; $display("FAIL first_lit_a got %h want %h", oa, FIRST_A); end
        if (ob !== FIRST_B) begin n_err++; $display("FAIL first_lit_b got %h want %h", ob, FIRST_B); end
    endtask

    // Four small-mode frames right after the first one: period, hsync window,
    // vsync width, vblank position and frame_count wrap.
    task automatic test_small_mode();
        int prev_ft = 0;
        int hs_cnt = 0, hs_bad = 0, vs_cnt = 0, vt_cnt = 0, vt_bad = 0;
        int fc_seen[$];
        int exp_seq[4] = '{2, 3, 0, 1};
        for (int i = 1; i <= 392; i++) begin
            drive(1'b1);
            ea = q_a.pop_front(); oa = obs_a();
            eb = q_b.pop_front(); ob = obs_b();
            n_vec += 2;
            if (oa !== ea) begin n_err++; $display("FAIL small_a got %h want %h", oa, ea); end
            if (ob !== eb) begin n_err++; $display("FAIL small_b got %h want %h", ob, eb); end
            if (b_hs) begin
                hs_cnt++;
                if (b_h < 4'd10 || b_h > 4'd11) hs_bad++;
            end
            if (!b_vs) vs_cnt++;
            if (b_vt) begin
                vt_cnt++;
                if (b_h != 4'd0 || b_v != 4'd4) vt_bad++;
            end
            if (b_ft) begin
                n_vec++;
                if (i - prev_ft != 98) begin
                    n_err++;
                    $display("FAIL small_period got %0d want 98", i - prev_ft);
                end
                prev_ft = i;
                fc_seen.push_back(int'(b_fc));
            end
        end
        n_vec += 5;
        if (hs_cnt != 56) begin n_err++; $display("FAIL small_hs_cnt got %0d want 56", hs_cnt); end
        if (hs_bad != 0)  begin n_err++; $display("FAIL small_hs_pos got %0d want 0", hs_bad); end
        if (vs_cnt != 56) begin n_err++; $display("FAIL small_vs_cnt got %0d want 56", vs_cnt); end
        if (vt_cnt != 4)  begin n_err++; $display("FAIL small_vt_cnt got %0d want 4", vt_cnt); end
        if (vt_bad != 0)  begin n_err++; $display("FAIL small_vt_pos got %0d want 0", vt_bad); end
        n_vec++;
        if (fc_seen.size() != 4) begin
            n_err++;
            $display("FAIL small_fc_len got %0d want 4", fc_seen.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (fc_seen[k] != exp_seq[k]) begin
                    n_err++;
                    $display("FAIL small_fc[%0d] got %0d want %0d", k, fc_seen[k], exp_seq[k]);
                end
            end
        end
    endtask

    // One full default-mode line measured between two line_ticks of dut_a.
    task automatic test_horizontal();
        int state = 0, start_i = 0, low_cnt = 0, first_low = -1, last_low = -1, de_fall = -1;
        logic prev_de = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            drive(1'b1);
            ea = q_a.pop_front(); oa = obs_a();
            eb = q_b.pop_front(); ob = obs_b();
            n_vec += 2;
            if (oa !== ea) begin n_err++; $display("FAIL horiz_a got %h want %h", oa, ea); end
            if (ob !== eb) begin n_err++; $display("FAIL horiz_b got %h want %h", ob, eb); end
            if (a_lt && state == 1) begin
                n_vec++;
                if (i - start_i != 800) begin
                    n_err++;
                    $display("FAIL line_period got %0d want 800", i - start_i);
                end
                state = 2;
            end else if (a_lt && state == 0) begin
                state   = 1;
                start_i = i;
            end
            if (state == 1) begin
                if (!a_hs) begin
                    low_cnt++;
                    if (first_low < 0) first_low = int'(a_h);
                    last_low = int'(a_h);
                end
                if (prev_de && !a_de) de_fall = int'(a_h);
            end
            prev_de = a_de;
        end
        n_vec += 5;
        if (state != 2)       begin n_err++; $display("FAIL line_window got %0d want 2", state); end
        if (low_cnt != 96)    begin n_err++; $display("FAIL hs_width got %0d want 96", low_cnt); end
        if (first_low != 656) begin n_err++; $display("FAIL hs_first got %0d want 656", first_low); end
        if (last_low != 751)  begin n_err++; $display("FAIL hs_last got %0d want 751", last_low); end
        if (de_fall != 640)   begin n_err++; $display("FAIL de_fall got %0d want 640", de_fall); end
    endtask

    // pix_en one clock in four.
    task automatic test_pix_en_gating();
        int prev_lt = -1, prev_ft = -1, wide = 0, lt_pairs = 0, ft_pairs = 0;
        bit en;
        for (int i = 0; i < 6800; i++) begin
            en = (i % 4 == 0);
            drive(en);
            ea = q_a.pop_front(); oa = obs_a();
            eb = q_b.pop_front(); ob = obs_b();
            n_vec += 2;
            if (oa !== ea) begin n_err++; $display("FAIL gate_a got %h want %h", oa, ea); end
            if (ob !== eb) begin n_err++; $display("FAIL gate_b got %h want %h", ob, eb); end
            if (!en && (a_lt || a_ft || a_vt || b_lt || b_ft || b_vt)) wide++;
            if (a_lt) begin
                if (prev_lt >= 0) begin
                    lt_pairs++;
                    n_vec++;
                    if (i - prev_lt != 3200) begin
                        n_err++;
                        $display("FAIL gate_line got %0d want 3200", i - prev_lt);
                    end
                end
                prev_lt = i;
            end
            if (b_ft) begin
                if (prev_ft >= 0) begin
                    ft_pairs++;
                    n_vec++;
                    if (i - prev_ft != 392) begin
                        n_err++;
                        $display("FAIL gate_frame got %0d want 392", i - prev_ft);
                    end
                end
                prev_ft = i;
            end
        end
        n_vec += 3;
        if (wide != 0)     begin n_err++; $display("FAIL tick_width got %0d want 0", wide); end
        if (lt_pairs < 1)  begin n_err++; $display("FAIL gate_line_seen got %0d want >=1", lt_pairs); end
        if (ft_pairs < 10) begin n_err++; $display("FAIL gate_frame_seen got %0d want >=10", ft_pairs); end
    endtask

    task automatic test_midframe_reset();
        int n;
        n = (300 - mh[0] + 800) % 800;
        for (int i = 0; i < n; i++) begin
            drive(1'b1);
            ea = q_a.pop_front(); oa = obs_a();
            eb = q_b.pop_front(); ob = obs_b();
            n_vec += 2;
            if (oa !== ea) begin n_err++; $display("FAIL pre_rst_a got %h want %h", oa, ea); end
            if (ob !== eb) begin n_err++; $display("FAIL pre_rst_b got %h want %h", ob, eb); end
        end
        // Assert between edges: outputs must reset without waiting for a clock.
        #2 rst_n = 1'b0;
        #1;
        n_vec += 2;
        if (obs_a() !== RST_A) begin n_err++; $display("FAIL async_rst_a got %h want %h", obs_a(), RST_A); end
        if (obs_b() !== RST_B) begin n_err++; $display("FAIL async_rst_b got %h want %h", obs_b(), RST_B); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_vec += 2;
            if (obs_a() !== RST_A) begin n_err++; $display("FAIL in_rst_a got %h want %h", obs_a(), RST_A); end
            if (obs_b() !== RST_B) begin n_err++; $display("FAIL in_rst_b got %h want %h", obs_b(), RST_B); end
        end
        rst_n = 1'b1;
        model_reset();
        drive(1'b1);
        ea = q_a.pop_front(); oa = obs_a();
        eb = q_b.pop_front(); ob = obs_b();
        n_vec += 4;
        if (oa !== FIRST_A) begin n_err++; $display("FAIL rst_first_a got %h want %h", oa, FIRST_A); end
        if (ob !== FIRST_B) begin n_err++; $display("FAIL rst_first_b got %h want %h", ob, FIRST_B); end
        if (oa !== ea)      begin n_err++; $display("FAIL rst_sb_a got %h want %h", oa, ea); end
        if (ob !== eb)      begin n_err++; $display("FAIL rst_sb_b got %h want %h", ob, eb); end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1);
            ea = q_a.pop_front(); oa = obs_a();
            eb = q_b.pop_front(); ob = obs_b();
            n_vec += 2;
            if (oa !== ea) begin n_err++; $display("FAIL post_rst_a got %h want %h", oa, ea); end
            if (ob !== eb) begin n_err++; $display("FAIL post_rst_b got %h want %h", ob, eb); end
        end
    endtask

    initial begin
        md[0] = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33,
                  hp:1'b0, vp:1'b0, fmod:256};
        md[1] = '{hd:8, hf:2, hs:2, hb:2, vd:4, vf:1, vs:1, vb:1,
                  hp:1'b1, vp:1'b0, fmod:4};
        model_reset();
        test_reset();
        test_first_frame();
        test_small_mode();
        test_horizontal();
        test_pix_en_gating();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
